// File: rtl/modbus_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between a keyboard (1 byte)
// and a Modbus framer (FRAME_LEN bytes), with an enforced idle gap and a per-byte timeout.
module modbus_tx_arb #(
   parameter int FRAME_LEN = 7,
   parameter int GAP_CYC   = 16,
   parameter int TIMEOUT   = 65535
) (
   input  logic                   CLK,
   input  logic                   RSTn,
   input  logic                   K_Req,
   input  logic [7:0]             K_Data,
   output logic                   K_Ack,
   input  logic                   M_Req,
   input  logic [8*FRAME_LEN-1:0] M_Frame,
   output logic                   M_Ack,
   output logic                   TX_En_Sig,
   output logic [7:0]             TX_Data,
   input  logic                   TX_Done_Sig,
   output logic [1:0]             Grant,
   output logic                   Err
);

   localparam int IW    = (FRAME_LEN > 8) ? $clog2(FRAME_LEN) : 3;
   localparam int GW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam int DEPTH = 2 ** IW;

   localparam logic [IW-1:0] LAST_M  = IW'(FRAME_LEN - 1);
   localparam logic [GW-1:0] GAP_END = GW'(GAP_CYC - 1);
   localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT);

   typedef enum logic [2:0] {IDLE, LOAD, SEND, NEXT, GAP} state_t;

   state_t        state;
   logic [IW-1:0] idx;
   logic [IW-1:0] last_idx;
   logic [GW-1:0] gap_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          last_m;
   logic          own_m;
   logic [7:0]    buffer [DEPTH];

   logic          pick_k;
   logic          pick_m;
   logic          capture;
   logic [IW-1:0] idx_inc;
   logic [TW-1:0] tmo_nxt;

   // last_m=1 after reset so the keyboard wins the first simultaneous request
   always_comb begin
      pick_k  = K_Req & (~M_Req | last_m);
      pick_m  = M_Req & ~pick_k;
      capture = (state == IDLE) & ~RSTn & (K_Req | M_Req);
      idx_inc = idx + 1'b1;
      tmo_nxt = tmo_cnt + 1'b1;
   end

   // Byte 0 of the frame sits at the MSBs; store it at buffer[0]
   always_ff @(posedge CLK) begin
      if (capture) begin
         if (pick_k)
            buffer[0] <= K_Data;
         else
            for (int i = 0; i < FRAME_LEN; i++)
               buffer[i] <= M_Frame[8*(FRAME_LEN-1-i) +: 8];
      end
   end

   always_ff @(posedge CLK) begin
      if (RSTn) begin
         state     <= IDLE;
         TX_En_Sig <= 1'b0;
         TX_Data   <= 8'h00;
         K_Ack     <= 1'b0;
         M_Ack     <= 1'b0;
         Grant     <= 2'b00;
         Err       <= 1'b0;
         idx       <= '0;
         last_idx  <= '0;
         gap_cnt   <= '0;
         tmo_cnt   <= '0;
         last_m    <= 1'b1;
         own_m     <= 1'b0;
      end else begin
         K_Ack <= 1'b0;
         M_Ack <= 1'b0;
         Err   <= 1'b0;
         case (state)
            IDLE: begin
               if (K_Req | M_Req) begin
                  own_m    <= pick_m;
                  K_Ack    <= pick_k;
                  M_Ack    <= pick_m;
                  Grant    <= {pick_m, pick_k};
                  idx      <= '0;
                  last_idx <= pick_m ? LAST_M : '0;
                  TX_Data  <= pick_m ? M_Frame[8*FRAME_LEN-1 -: 8] : K_Data;
                  tmo_cnt  <= '0;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               TX_Data   <= buffer[idx];
               TX_En_Sig <= 1'b1;
               state     <= SEND;
            end
            SEND: begin
               if (TX_Done_Sig) begin
                  TX_En_Sig <= 1'b0;
                  tmo_cnt   <= '0;
                  if (idx == last_idx) begin
                     Grant   <= 2'b00;
                     gap_cnt <= '0;
                     last_m  <= own_m;
                     state   <= GAP;
                  end else begin
                     idx     <= idx_inc;
                     TX_Data <= buffer[idx_inc];
                     state   <= NEXT;
                  end
               end else if (tmo_nxt == TMO_END) begin
                  // stuck transmitter: abandon the rest of this transaction
                  Err       <= 1'b1;
                  TX_En_Sig <= 1'b0;
                  tmo_cnt   <= '0;
                  Grant     <= 2'b00;
                  gap_cnt   <= '0;
                  last_m    <= own_m;
                  state     <= GAP;
               end else begin
                  tmo_cnt <= tmo_nxt;
               end
            end
            NEXT: begin
               TX_En_Sig <= 1'b1;
               state     <= SEND;
            end
            GAP: begin
               if (gap_cnt == GAP_END)
                  state <= IDLE;
               else
                  gap_cnt <= gap_cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/modbus_tx_arb.md
MODBUS_TX_ARB -- requirements
Module: modbus_tx_arb

Interface
REQ-001 Parameter FRAME_LEN, default 7, bytes per Modbus frame requester transaction.
REQ-002 Parameter GAP_CYC, default 16, idle CLK cycles enforced after every completed transaction.
REQ-003 Parameter TIMEOUT, default 65535, max CLK cycles waited for TX_Done_Sig per byte.
REQ-004 CLK  input  1  sole clock, all logic on rising edge.
REQ-005 RSTn  input  1  reset: synchronous, active-high (asserted when RSTn=1).
REQ-006 K_Req  input  1  keyboard requester: one scan-code byte pending; level, held until K_Ack.
REQ-007 K_Data  input  8  keyboard byte; valid while K_Req=1.
REQ-008 K_Ack  output  1  one-cycle pulse: K_Data captured.
REQ-009 M_Req  input  1  Modbus requester: one frame pending; level, held until M_Ack.
REQ-010 M_Frame  input  8*FRAME_LEN  frame bytes; byte 0 at MSBs, sent first.
REQ-011 M_Ack  output  1  one-cycle pulse: M_Frame captured.
REQ-012 TX_En_Sig  output  1  enable to shared UART TX; high while one byte is in flight.
REQ-013 TX_Data  output  8  byte to UART TX; stable whenever TX_En_Sig=1.
REQ-014 TX_Done_Sig  input  1  one-cycle pulse from UART TX: current byte finished.
REQ-015 Grant  output  2  01 keyboard owns TX, 10 Modbus owns TX, 00 none; never 11.
REQ-016 Err  output  1  one-cycle pulse on byte timeout.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, SEND, NEXT, GAP.
REQ-018 IDLE: if any request, arbitrate, capture winner data into internal buffer, pulse matching Ack, set Grant, go LOAD; same cycle.
REQ-019 Arbitration SHALL be round-robin: on simultaneous K_Req and M_Req, winner is the requester not granted last; after reset keyboard wins first.
REQ-020 Lone request SHALL be granted regardless of round-robin pointer.
REQ-021 Keyboard transaction length 1 byte; Modbus length FRAME_LEN bytes; byte index counter reset to 0 at capture.
REQ-022 LOAD: drive TX_Data = buffer[index], TX_En_Sig=0, go SEND next cycle.
REQ-023 SEND: TX_En_Sig=1, TX_Data held; timeout counter increments each cycle.
REQ-024 SEND with TX_Done_Sig=1: if index = length-1 go GAP, else index+1 and go NEXT; TX_En_Sig low next cycle.
REQ-025 NEXT: TX_En_Sig=0 exactly one cycle, TX_Data updated to next byte, then SEND.
REQ-026 Transaction SHALL be atomic: requests arriving mid-transaction are not granted until GAP completes.
REQ-027 GAP: Grant=00, TX_En_Sig=0, count GAP_CYC cycles, then IDLE; round-robin pointer updated on GAP entry.
REQ-028 Timeout: timeout counter reaching TIMEOUT in SEND SHALL pulse Err, drop remaining bytes, go GAP.
REQ-029 TX_Done_Sig outside SEND SHALL be ignored.
REQ-030 Buffer SHALL not change between capture and GAP; requester input changes after Ack have no effect.
REQ-031 Latency: request seen in IDLE at cycle N -> Ack at N+1 edge, TX_En_Sig=1 first at cycle N+2.
REQ-032 Counters: byte index 3 bits min, gap and timeout counters sized from parameters, no wrap-around in use.

Reset
REQ-033 RSTn=1 at a clock edge SHALL force IDLE, TX_En_Sig=0, TX_Data=00, K_Ack=0, M_Ack=0, Grant=00, Err=0, all counters 0, round-robin pointer to keyboard-first.
REQ-034 Reset mid-transaction SHALL abort immediately; no Ack or Err pulse generated; pending requests re-arbitrated after release.

Verification
REQ-035 K_Req=1, K_Data=0x1C, TX_Done_Sig 10 cycles after TX_En_Sig rises -> one K_Ack, TX_Data=0x1C, Grant=01, then GAP_CYC idle, Grant=00.
REQ-036 M_Req=1, M_Frame=01 03 00 00 00 01 84 -> 7 SEND phases in order 01,03,00,00,00,01,84, TX_En_Sig low one cycle between bytes, single M_Ack.
REQ-037 K_Req and M_Req asserted same cycle after reset, both held -> keyboard byte first, then Modbus frame after gap, then keyboard again (round-robin).
REQ-038 K_Req rises during Modbus byte 3 -> no K_Ack until gap after byte 6 ends; Modbus frame uninterrupted.
REQ-039 TIMEOUT=20, TX_Done_Sig withheld -> Err pulse at 20th SEND cycle, GAP, IDLE, no further bytes of that frame.
REQ-040 RSTn=1 for one cycle during Modbus byte 2 -> all outputs at reset values next cycle; held M_Req re-granted from byte 0.
